counter_2bit: RTL and testbench

- Free-running 2-bit binary counter with enable, direction control, synchronous load and a registered wrap flag.
- Used as a small cycle/phase counter in sequential datapaths.
- With en=1, up_dn=1 and load=0, it counts 00->01->10->11->00 on successive rising clock edges.

---
 rtl/counter_2bit.sv | 67 ++++++
 tb/tb_counter_2bit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/counter_2bit.sv
// Up/down WIDTH-bit counter with enable, synchronous load and a registered wrap pulse.
// Define COUNTER_2BIT_SATURATE_EN to clamp at the limits; wrap then marks arrival at a limit.
module counter_2bit #(
  parameter int unsigned           WIDTH     = 2,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] dout,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] dout_d, dout_q;
  logic             wrap_d, wrap_q;

  always_comb begin
    dout_d = dout_q;
    wrap_d = 1'b0;
    if (load) begin
      dout_d = load_val;
    end else if (en) begin
`ifdef COUNTER_2BIT_SATURATE_EN
      // wrap fires only on the edge that lands on the limit, never while parked there
      if (up_dn) begin
        if (dout_q != CNT_MAX) begin
          dout_d = dout_q + CNT_ONE;
          wrap_d = (dout_q == (CNT_MAX - CNT_ONE));
        end
      end else begin
        if (dout_q != '0) begin
          dout_d = dout_q - CNT_ONE;
          wrap_d = (dout_q == CNT_ONE);
        end
      end
`else
      if (up_dn) begin
        dout_d = dout_q + CNT_ONE;
        wrap_d = (dout_q == CNT_MAX);
      end else begin
        dout_d = dout_q - CNT_ONE;
        wrap_d = (dout_q == '0);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q <= RESET_VAL;
      wrap_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
      wrap_q <= wrap_d;
    end
  end

  assign dout = dout_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_counter_2bit.sv
// Directed self-checking bench for counter_2bit; expectations follow COUNTER_2BIT_SATURATE_EN.
module tb_counter_2bit;

  localparam int unsigned WIDTH = 2;

  logic             clk;
  logic             reset;
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] dout;
  logic             wrap;

  int unsigned tests_run;
  int unsigned tests_failed;

  counter_2bit #(
    .WIDTH     (WIDTH),
    .RESET_VAL (2'b00)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .dout     (dout),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic cyc(input string tag, input logic ld, input logic [WIDTH-1:0] lv,
                     input logic e, input logic up,
                     input logic [WIDTH-1:0] exp_dout, input logic exp_wrap);
    load     = ld;
    load_val = lv;
    en       = e;
    up_dn    = up;
    @(posedge clk);
    #1;
    check({tag, ".dout"}, 32'(dout), 32'(exp_dout));
    check({tag, ".wrap"}, 32'(wrap), 32'(exp_wrap));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset    = 1'b0;
    en       = 1'b1;
    up_dn    = 1'b1;
    load     = 1'b0;
    load_val = '0;
    #2;
    check("rst.dout", 32'(dout), 32'd0);
    check("rst.wrap", 32'(wrap), 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold.dout", 32'(dout), 32'd0);
    check("rst_hold.wrap", 32'(wrap), 32'd0);
    reset = 1'b1;

`ifdef COUNTER_2BIT_SATURATE_EN
    cyc("sat_up0", 1'b0, 2'b00, 1'b1, 1'b1, 2'b01, 1'b0);
    cyc("sat_up1", 1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0);
    cyc("sat_up2", 1'b0, 2'b00, 1'b1, 1'b1, 2'b11, 1'b1);
    cyc("sat_up3", 1'b0, 2'b00, 1'b1, 1'b1, 2'b11, 1'b0);
    cyc("sat_up4", 1'b0, 2'b00, 1'b1, 1'b1, 2'b11, 1'b0);
    cyc("sat_dn0", 1'b0, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0);
    cyc("sat_dn1", 1'b0, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0);
    cyc("sat_dn2", 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b1);
    cyc("sat_dn3", 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0);
    cyc("sat_ld",  1'b1, 2'b11, 1'b1, 1'b0, 2'b11, 1'b0);
    cyc("sat_ld2", 1'b1, 2'b10, 1'b1, 1'b1, 2'b10, 1'b0);
    cyc("sat_up5", 1'b0, 2'b00, 1'b1, 1'b1, 2'b11, 1'b1);
    cyc("sat_hld", 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0);
    cyc("sat_dn4", 1'b0, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0);
`else
    cyc("up0", 1'b0, 2'b00, 1'b1, 1'b1, 2'b01, 1'b0);
    cyc("up1", 1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0);
    cyc("up2", 1'b0, 2'b00, 1'b1, 1'b1, 2'b11, 1'b0);
    cyc("up3", 1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1);
    cyc("up4", 1'b0, 2'b00, 1'b1, 1'b1, 2'b01, 1'b0);
    cyc("dn0", 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0);
    cyc("dn1", 1'b0, 2'b00, 1'b1, 1'b0, 2'b11, 1'b1);
    cyc("dn2", 1'b0, 2'b00, 1'b1, 1'b0, 2'b10, 1'b0);
    cyc("dn3", 1'b0, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0);
    cyc("dn4", 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0);
    cyc("pre_hold0", 1'b0, 2'b00, 1'b1, 1'b1, 2'b01, 1'b0);
    cyc("pre_hold1", 1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc("hold", 1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0);
    cyc("hold_rel", 1'b0, 2'b00, 1'b1, 1'b1, 2'b11, 1'b0);
    cyc("ld_prio",  1'b1, 2'b11, 1'b1, 1'b1, 2'b11, 1'b0);
    cyc("ld_next",  1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 1'b1);
    cyc("ld_wrapclr", 1'b1, 2'b01, 1'b0, 1'b0, 2'b01, 1'b0);
    cyc("ld_dn",    1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0);
    cyc("dir_flip", 1'b0, 2'b00, 1'b1, 1'b1, 2'b01, 1'b0);
    cyc("mid0",     1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0);
`endif

    // Asynchronous reset between edges, then resume counting from zero.
    #2;
    reset = 1'b0;
    #1;
    check("arst.dout", 32'(dout), 32'd0);
    check("arst.wrap", 32'(wrap), 32'd0);
    en    = 1'b1;
    up_dn = 1'b1;
    load  = 1'b0;
    @(posedge clk);
    #1;
    check("arst_hold.dout", 32'(dout), 32'd0);
    reset = 1'b1;
    cyc("arst_rel", 1'b0, 2'b00, 1'b1, 1'b1, 2'b01, 1'b0);
    cyc("arst_rel2", 1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
